// File: rtl/ram_bist_ctrl.sv
// ram_bist_ctrl: RAM self-test; writes a seed pattern through port A, reads it back
// through port B, then repeats with the inverted pattern and reports the result.
module ram_bist_ctrl #(
    parameter int data_width = 3,
    parameter int addr_width = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [data_width-1:0] seed,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [addr_width:0]   err_cnt,
    output logic [addr_width-1:0] fail_addr,
    output logic                  ram_choice_a,
    output logic                  ram_choice_b,
    output logic                  ram_we,
    output logic [addr_width-1:0] ram_addr_a,
    output logic [addr_width-1:0] ram_addr_b,
    output logic [data_width-1:0] ram_din_a,
    output logic [data_width-1:0] ram_din_b,
    input  logic [data_width-1:0] ram_dout_b
);
    typedef enum logic [2:0] {IDLE, WR0, RD0, WR1, RD1, FLUSH, DONE} state_t;

    state_t                state, state_n;
    logic [addr_width-1:0] cnt, cnt_n, chk_addr;
    logic [data_width-1:0] seed_q, seed_n, chk_exp;
    logic [addr_width:0]   err_n;
    logic                  chk_vld, first_q, accept, miss, wr_n, rd_n, inv_n;

    function automatic logic [data_width-1:0] pat(input logic [addr_width-1:0] a,
                                                  input logic [data_width-1:0] s,
                                                  input logic inv);
        logic [data_width-1:0] e;
        e = data_width'(a) ^ s;
        return inv ? ~e : e;
    endfunction

    assign ram_din_b = '0;

    always_comb begin
        accept  = start && (state == IDLE || state == DONE);
        state_n = state;
        cnt_n   = cnt;
        if (accept) begin
            state_n = WR0;
            cnt_n   = '0;
        end else if (state != IDLE && state != DONE) begin
            cnt_n = state == FLUSH ? cnt : cnt + addr_width'(1);
            if (state == FLUSH || &cnt) state_n = state_t'(state + 3'd1);
        end
        seed_n = accept ? seed : seed_q;
        wr_n   = state_n == WR0 || state_n == WR1;
        rd_n   = state_n == RD0 || state_n == RD1;
        inv_n  = state_n == WR1 || state_n == RD1;
        miss   = chk_vld && ram_dout_b != chk_exp;
        // err_cnt cannot represent 2*depth, so it holds at all-ones
        err_n  = (miss && !(&err_cnt)) ? err_cnt + (addr_width+1)'(1) : err_cnt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            seed_q       <= '0;
            chk_vld      <= 1'b0;
            chk_addr     <= '0;
            chk_exp      <= '0;
            first_q      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            err_cnt      <= '0;
            fail_addr    <= '0;
            ram_we       <= 1'b0;
            ram_choice_a <= 1'b0;
            ram_choice_b <= 1'b0;
            ram_addr_a   <= '0;
            ram_addr_b   <= '0;
            ram_din_a    <= '0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            seed_q       <= seed_n;
            chk_vld      <= state == RD0 || state == RD1;
            chk_addr     <= cnt;
            chk_exp      <= pat(cnt, seed_q, state == RD1);
            busy         <= state_n != IDLE && state_n != DONE;
            ram_we       <= wr_n;
            ram_choice_a <= wr_n;
            ram_choice_b <= rd_n;
            ram_addr_a   <= wr_n ? cnt_n : '0;
            ram_addr_b   <= rd_n ? cnt_n : '0;
            ram_din_a    <= wr_n ? pat(cnt_n, seed_n, inv_n) : '0;
            if (accept) begin
                err_cnt   <= '0;
                fail_addr <= '0;
                first_q   <= 1'b0;
                done      <= 1'b0;
                pass      <= 1'b0;
            end else begin
                err_cnt <= err_n;
                done    <= state_n == DONE;
                pass    <= state_n == DONE && err_n == '0;
                if (miss && !first_q) begin
                    fail_addr <= chk_addr;
                    first_q   <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_ram_bist_ctrl.sv
// tb_ram_bist_ctrl: directed runs against a RAM model with optional stuck-at-0 bits;
// expected outcomes are queued per run and popped when done rises.
module tb_ram_bist_ctrl;
    localparam int DW = 3;
    localparam int AW = 3;
    localparam int D  = 1 << AW;

    typedef struct {
        int err;
        int fail;
        int ok;
    } exp_t;

    logic          clk = 0;
    logic          rst_n = 0;
    logic          start = 0;
    logic [DW-1:0] seed = '0;
    logic          busy, done, pass, ram_choice_a, ram_choice_b, ram_we;
    logic [AW:0]   err_cnt;
    logic [AW-1:0] fail_addr, ram_addr_a, ram_addr_b;
    logic [DW-1:0] ram_din_a, ram_din_b;
    logic [DW-1:0] ram_dout_b = '0;
    logic [DW-1:0] mem [D];
    logic [DW-1:0] stuck [D] = '{default: '0};
    logic [DW-1:0] cur_seed = '0;
    logic [DW-1:0] wexp;
    exp_t          q[$];
    int            total = 0;
    int            bad = 0;
    int            wcnt = 0;

    ram_bist_ctrl #(.data_width(DW), .addr_width(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .seed(seed),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt), .fail_addr(fail_addr),
        .ram_choice_a(ram_choice_a), .ram_choice_b(ram_choice_b), .ram_we(ram_we),
        .ram_addr_a(ram_addr_a), .ram_addr_b(ram_addr_b),
        .ram_din_a(ram_din_a), .ram_din_b(ram_din_b), .ram_dout_b(ram_dout_b)
    );

    initial forever #5 clk = ~clk;

    // dual-port RAM with registered port-B read and per-address stuck-at-0 bits
    always @(posedge clk) begin
        if (ram_choice_a && ram_we) mem[ram_addr_a] <= ram_din_a & ~stuck[ram_addr_a];
        if (ram_choice_b) ram_dout_b <= mem[ram_addr_b];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // write-stream monitor: 8 writes of a^seed, then 8 of ~(a^seed)
    always @(negedge clk) begin
        if (!busy) wcnt = 0;
        else if (ram_we) begin
            wexp = DW'(wcnt % D) ^ cur_seed;
            if (wcnt >= D) wexp = ~wexp;
            check("wr_addr", 32'(ram_addr_a), 32'(wcnt % D));
            check("wr_data", 32'(ram_din_a), 32'(wexp));
            wcnt++;
        end
    end

    task automatic run(input logic [DW-1:0] s, input bit poke);
        int   n;
        int   bc;
        exp_t e;
        cur_seed = s;
        @(negedge clk);
        seed  = s;
        start = 1;
        @(negedge clk);
        start = 0;
        n  = 1;
        bc = 0;
        check("done_clr", 32'(done), 0);
        while (!done && n < 200) begin
            bc += int'(busy);
            start = poke && n == 12;
            if (poke && n == 12) seed = ~s;
            @(negedge clk);
            n++;
        end
        start = 0;
        e = q.pop_front();
        check("done_cyc", n, 34);
        check("busy_cyc", bc, 33);
        check("pass", 32'(pass), e.ok);
        check("err_cnt", 32'(err_cnt), e.err);
        check("fail_addr", 32'(fail_addr), e.fail);
        check("busy_off", 32'(busy), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_outs", {busy, done, pass, err_cnt, fail_addr, ram_we, ram_choice_a,
                           ram_choice_b, ram_addr_a, ram_addr_b, ram_din_a, ram_din_b}, 0);
        rst_n = 1;
        q.push_back('{0, 0, 1});
        run(3'b000, 0);
        q.push_back('{0, 0, 1});
        run(3'b101, 0);
        stuck[5] = 3'b001;
        q.push_back('{1, 5, 0});
        run(3'b000, 0);
        stuck[5] = 3'b000;
        stuck[3] = 3'b001;
        stuck[6] = 3'b001;
        q.push_back('{2, 3, 0});
        run(3'b000, 0);
        stuck[3] = 3'b000;
        stuck[6] = 3'b000;
        q.push_back('{0, 0, 1});
        run(3'b011, 1);
        cur_seed = 3'b010;
        @(negedge clk);
        seed  = 3'b010;
        start = 1;
        @(negedge clk);
        start = 0;
        repeat (11) @(negedge clk);
        check("mid_busy", 32'(busy), 1);
        rst_n = 0;
        #1;
        check("mid_rst_outs", {busy, done, pass, err_cnt, fail_addr, ram_we, ram_choice_a,
                               ram_choice_b, ram_addr_a, ram_addr_b, ram_din_a, ram_din_b}, 0);
        @(negedge clk);
        rst_n = 1;
        q.push_back('{0, 0, 1});
        run(3'b010, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
